// File: rtl/reset_sequencer_pkg.sv
// reset_seq_pkg: state encoding and reset-cause definitions shared by the reset sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        COUNT,
        PERIPH,
        RUN
    } state_t;

    localparam int CAUSE_W    = 5;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_EXT  = 1;
    localparam int CAUSE_LOCK = 2;
    localparam int CAUSE_SW   = 3;
    localparam int CAUSE_WDT  = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_POR_INIT = CAUSE_W'(1 << CAUSE_POR);

    function automatic logic [CAUSE_W-1:0] cause_bit(input int idx);
        logic [CAUSE_W-1:0] c;
        c      = '0;
        c[idx] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// lock_filter: synchronizes the raw PLL lock and debounces it over LOCK_FILTER cycles
module lock_filter #(
    parameter int LOCK_FILTER = 4
) (
    input  logic clk25,
    input  logic rst,
    input  logic lock,
    output logic lock_s,
    output logic lock_ok
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic          meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk25) begin
        if (rst) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= lock;
            lock_s <= meta;
            cnt    <= !lock_s ? '0 : (cnt == CW'(LOCK_FILTER)) ? cnt : cnt + 1'b1;
        end
    end

    assign lock_ok = cnt == CW'(LOCK_FILTER);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged peripheral/CPU reset release from PLL lock, with watchdog and cause capture
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER  = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8,
    parameter int WDT_BITS     = 24
) (
    input  logic               clk25,
    input  logic               rst,
    input  logic               lock,
    input  logic               sw_rst,
    input  logic               wdt_en,
    input  logic               wdt_kick,
    output logic               rst_periph,
    output logic               rst_cpu,
    output logic               ready,
    output logic [CAUSE_W-1:0] cause
);

    localparam int CNT_MAX = HOLD_CYCLES > STAGE_CYCLES ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state;
    state_t               next;
    logic [CNT_W-1:0]     cnt;
    logic [WDT_BITS-1:0]  wdt;
    logic [CAUSE_W-1:0]   cause_q = CAUSE_POR_INIT;
    logic [CAUSE_W-1:0]   next_cause;
    logic                 lock_s;
    logic                 lock_ok;
    logic                 run;
    logic                 lock_loss;
    logic                 timeout;

    lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
        .clk25   (clk25),
        .rst     (rst),
        .lock    (lock),
        .lock_s  (lock_s),
        .lock_ok (lock_ok)
    );

    assign run       = state == RUN;
    assign lock_loss = !lock_s && (state inside {COUNT, PERIPH, RUN});
    assign timeout   = run && wdt_en && (&wdt) && !wdt_kick;
    assign cause     = cause_q;

    // Events are listed in priority order; rst is handled in the register process.
    always_comb begin
        next       = state;
        next_cause = cause_q;
        if (lock_loss) begin
            next       = HOLD;
            next_cause = cause_bit(CAUSE_LOCK);
        end else if (timeout) begin
            next       = HOLD;
            next_cause = cause_bit(CAUSE_WDT);
        end else if (run && sw_rst) begin
            next       = HOLD;
            next_cause = cause_bit(CAUSE_SW);
        end else begin
            case (state)
                HOLD:      next = WAIT_LOCK;
                WAIT_LOCK: next = lock_ok ? COUNT : WAIT_LOCK;
                COUNT:     next = (cnt == CNT_W'(HOLD_CYCLES - 1)) ? PERIPH : COUNT;
                PERIPH:    next = (cnt == CNT_W'(STAGE_CYCLES - 1)) ? RUN : PERIPH;
                default:   next = state;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= HOLD;
            cnt        <= '0;
            wdt        <= '0;
            cause_q    <= cause_bit(CAUSE_EXT);
            rst_periph <= 1'b1;
            rst_cpu    <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state      <= next;
            cause_q    <= next_cause;
            cnt        <= (next == state && (state inside {COUNT, PERIPH})) ? cnt + 1'b1 : '0;
            wdt        <= (!run || !wdt_en || wdt_kick) ? '0 : (&wdt) ? wdt : wdt + 1'b1;
            rst_periph <= !(next inside {PERIPH, RUN});
            rst_cpu    <= next != RUN;
            ready      <= next == RUN;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: timestamp-based reference model of the reset sequencer with directed and random stimulus
module tb_reset_sequencer;

    localparam int LF   = 4;
    localparam int H    = 16;
    localparam int S    = 8;
    localparam int WB   = 8;
    localparam int WMAX = (1 << WB) - 1;
    localparam int MAXE = 20000;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       sw_rst = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       rst_periph;
    logic       rst_cpu;
    logic       ready;
    logic [4:0] cause;

    always #20 clk25 = ~clk25;

    reset_sequencer #(
        .LOCK_FILTER  (LF),
        .HOLD_CYCLES  (H),
        .STAGE_CYCLES (S),
        .WDT_BITS     (WB)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .lock       (lock),
        .sw_rst     (sw_rst),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .rst_periph (rst_periph),
        .rst_cpu    (rst_cpu),
        .ready      (ready),
        .cause      (cause)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: edge history of lock/rst plus timestamps of the last reset and lock acceptance.
    bit         lk[0:MAXE];
    bit         rr[0:MAXE];
    int         n = 0;
    int         t0 = -1;
    int         h = -10;
    int         wd = 0;
    logic [4:0] m_cause = 5'b00001;
    bit         exp_rp = 1'b1;
    bit         exp_rc = 1'b1;

    function automatic bit ls_b(input int k);
        if (k < 2) return 1'b0;
        return !rr[k-1] && !rr[k-2] && lk[k-2];
    endfunction

    function automatic bit ok_b(input int k);
        if (k <= LF + 2) return 1'b0;
        for (int j = k - LF; j < k; j++)
            if (rr[j] || !ls_b(j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit l, input bit s, input bit e, input bit kk);
        bit inseq, runb, to;
        rst = r; lock = l; sw_rst = s; wdt_en = e; wdt_kick = kk;
        @(posedge clk25);
        n++;
        lk[n] = l;
        rr[n] = r;
        inseq = t0 >= 0 && n > t0;
        runb  = t0 >= 0 && n > t0 + H + S;
        to    = runb && e && wd == WMAX && !kk;
        wd    = (runb && e && !kk) ? ((wd == WMAX) ? WMAX : wd + 1) : 0;
        if (r) begin
            m_cause = 5'b00010; t0 = -1; h = n;
        end else if (inseq && !ls_b(n)) begin
            m_cause = 5'b00100; t0 = -1; h = n;
        end else if (to) begin
            m_cause = 5'b10000; t0 = -1; h = n;
        end else if (runb && s) begin
            m_cause = 5'b01000; t0 = -1; h = n;
        end else if (t0 < 0 && n >= h + 2 && ok_b(n)) begin
            t0 = n;
        end
        exp_rp = !(t0 >= 0 && n >= t0 + H);
        exp_rc = !(t0 >= 0 && n >= t0 + H + S);
        #1;
        check($sformatf("rst_periph@%0d", n), rst_periph, exp_rp);
        check($sformatf("rst_cpu@%0d", n), rst_cpu, exp_rc);
        check($sformatf("ready@%0d", n), ready, !exp_rc);
        check($sformatf("cause@%0d", n), cause, m_cause);
    endtask

    task automatic go_run(input bit e);
        for (int i = 0; i < 200 && exp_rc; i++) step(0, 1, 0, e, 0);
        check("reach_run", ready, 1);
    endtask

    initial begin
        int g, lv, cyc;
        #1 check("por_cause", cause, 5'b00001);

        // Nominal power-up: rst on edges 1..3, lock first sampled high at edge 10.
        repeat (3) step(1, 0, 0, 0, 0);
        check("ext_cause", cause, 5'b00010);
        repeat (6) step(0, 0, 0, 0, 0);
        repeat (22) step(0, 1, 0, 0, 0);
        check("nom_rp_31", rst_periph, 1);
        step(0, 1, 0, 0, 0);
        check("nom_rp_32", rst_periph, 0);
        check("nom_rc_32", rst_cpu, 1);
        repeat (7) step(0, 1, 0, 0, 0);
        check("nom_ready_39", ready, 0);
        step(0, 1, 0, 0, 0);
        check("nom_ready_40", ready, 1);
        check("nom_rc_40", rst_cpu, 0);
        check("nom_cause", cause, 5'b00010);

        // Software reset in RUN.
        step(0, 1, 1, 0, 0);
        check("sw_cause", cause, 5'b01000);
        check("sw_rp", rst_periph, 1);

        // Lock glitch: 3 high, 1 low, then high; release shifts by 4 edges.
        repeat (2) step(1, 0, 0, 0, 0);
        g = n + 1;
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        while (n < g + 25) step(0, 1, 0, 0, 0);
        check("glitch_rp_hold", rst_periph, 1);
        step(0, 1, 0, 0, 0);
        check("glitch_rp_rel", rst_periph, 0);
        repeat (8) step(0, 1, 0, 0, 0);
        check("glitch_ready", ready, 1);

        // Lock loss in RUN, then re-lock.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("loss_still_ready", ready, 1);
        step(0, 0, 0, 0, 0);
        check("loss_ready", ready, 0);
        check("loss_rp", rst_periph, 1);
        check("loss_cause", cause, 5'b00100);
        g = n + 1;
        while (n < g + 21) step(0, 1, 0, 0, 0);
        check("relock_rp_hold", rst_periph, 1);
        step(0, 1, 0, 0, 0);
        check("relock_rp_rel", rst_periph, 0);
        repeat (8) step(0, 1, 0, 0, 0);
        check("relock_ready", ready, 1);

        // Watchdog timeout without kicks.
        cyc = 0;
        while (!exp_rc && cyc < 300) begin
            step(0, 1, 0, 1, 0);
            cyc++;
        end
        check("wdt_latency", cyc, 256);
        check("wdt_cause", cause, 5'b10000);

        // Kicks at count 254 and 255 keep RUN alive.
        go_run(1);
        for (int i = 0; i < 300 && wd != 254; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 300 && wd != 255; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 1);
        repeat (10) step(0, 1, 0, 1, 0);
        check("kick_ready", ready, 1);
        check("kick_cause", cause, 5'b10000);

        // sw_rst in PERIPH is ignored.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 100 && exp_rp; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("sw_periph_rp", rst_periph, 0);
        check("sw_periph_cause", cause, 5'b00010);

        // rst and sw_rst together in RUN.
        go_run(0);
        step(1, 1, 1, 0, 0);
        check("rst_sw_cause", cause, 5'b00010);

        // Lock loss and watchdog timeout on the same edge.
        go_run(1);
        for (int i = 0; i < 300 && wd != 253; i++) step(0, 1, 0, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        check("both_ready_pre", ready, 1);
        step(0, 0, 0, 1, 0);
        check("both_cause", cause, 5'b00100);
        check("both_ready", ready, 0);

        // Random traffic.
        lv = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) lv = !lv;
            if (!lv && $urandom_range(0, 7) == 0) lv = 1;
            step($urandom_range(0, 299) == 0, lv[0], $urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
